piso: RTL and testbench
=======================

// Module: piso
// PURPOSE
//   Parallel-in serial-out shift register. Captures a WIDTH-bit word on a load
//   strobe, then presents it on a 1-bit serial output, MSB first, one bit per
//   clock. Serialiser stage between a parallel datapath and a 1-wire link.
// PARAMETERS
//   WIDTH   4   parallel word width in bits (legal: >= 2)
// PORTS
//   clk   input   1      clock; all state updates on rising edge
//   rst   input   1      asynchronous, active-low reset (0 = reset)
//   in    input   WIDTH  parallel data word, sampled only when ld=1
//   ld    input   1      load strobe, synchronous, active-high
//   out   output  1      serial data, MSB of the shift register
//   valid output  1      present only with PISO_VALID_EN (see CONFIGURATION)
//   Declaration order is fixed: in, rst, clk, ld, out [, valid].
//   Positional instantiation relies on this order.
// BEHAVIOUR
//   - State: shift register sr[WIDTH-1:0]. out = sr[WIDTH-1], combinational
//     from the register with no logic between them.
//   - Reset: rst=0 immediately clears sr to 0, so out=0 (and valid=0),
//     independent of clk. On rst release, the first active edge follows
//     normal rules.
//   - At each posedge clk with rst=1:
//       ld=1 : sr <= in (load; no shift that cycle)
//       ld=0 : sr <= {sr[WIDTH-2:0],1'b0} (shift left, zero fill)
//   - Latency: out = in[WIDTH-1] right after the loading edge. Bit
//     in[WIDTH-1-k] appears after k further shift edges. After WIDTH shifts
//     out stays 0 until the next load.
//   - Load wins: ld=1 mid-word discards the remaining bits and loads the new
//     word. No handshake; the source must wait WIDTH cycles for a full word.
//   - Back-to-back loads: each ld edge reloads. Only the last word shifts out.
//   - ld held high for N edges: sr holds in; out = in[WIDTH-1] for N cycles.
//   - Reset mid-word aborts the word. Nothing resumes after reset.
//   - ld or in at X while rst=0 has no effect.
// CONFIGURATION
//   PISO_VALID_EN defined:
//     - Adds output valid and a down-counter cnt (width $clog2(WIDTH+1)).
//     - Load sets cnt=WIDTH. Each shift edge with cnt>0 decrements cnt.
//     - valid = (cnt != 0): high on the cycles out carries word bits,
//       low on zero-fill cycles. Reset clears cnt.
//   PISO_VALID_EN undefined:
//     - No valid port and no counter.
//     - Serial behaviour on out is identical in both builds.
// TESTING
//   1 Reset: rst=0 with sr nonzero -> out=0 with no clock edge. Release
//     rst, ld=0 -> out stays 0.
//   2 Load 4'hC, ld=0 for 4 cycles -> out 1,1,0,0 then 0 thereafter.
//     valid 1,1,1,1,0 when enabled.
//   3 Load 4'hC, shift 3 edges, load 4'hF -> out=1 for 4 cycles, then 0.
//     The truncated 4'hC word is never resumed.
//   4 Back-to-back loads 4'h0 then 4'h5 -> out 0 during the first word,
//     then 0,1,0,1.
//   5 Load 4'h1, 4 shifts -> out 0,0,0,1. Load 4'h7 -> 0,1,1,1.
//   6 Load 4'hF, shift 2 edges, assert rst=0 mid-clock -> out=0 at once.
//     After release, zeros only until the next load.
//   Check out at every negedge against a reference model.
//   Run cases 1-6 in both builds (PISO_VALID_EN defined and undefined).

Source files
------------

// File: rtl/piso.sv
// Parallel-in serial-out shift register: loads a WIDTH-bit word on ld and shifts it out MSB first.
// Build option PISO_VALID_EN adds a valid output that marks the cycles carrying word bits.
module piso #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  input  logic             rst,
  input  logic             clk,
  input  logic             ld,
  output logic             out
`ifdef PISO_VALID_EN
  ,
  output logic             valid
`endif
);

  // There is no handshake. A load is accepted on every edge where ld=1.
  // It replaces whatever word is still shifting out.
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    sr_next = sr;
    if (ld) begin
      sr_next = in;
    end else begin
      sr_next = {sr[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr <= sr_next;
    end
  end

  assign out = sr[WIDTH-1];

`ifdef PISO_VALID_EN
  localparam int CW = $clog2(WIDTH + 1);

  // cnt counts the word bits still to be presented, including the one on out now.
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (ld) begin
      cnt_next = CW'(WIDTH);
    end else if (cnt != '0) begin
      cnt_next = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign valid = (cnt != '0);
`endif

endmodule

// File: tb/tb_piso.sv
// Bench for piso: a reference model pushes the expected {valid,out} for each edge, and the bench checks it at the following negedge.
// Build it with and without PISO_VALID_EN.
module tb_piso;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [W-1:0] d_in;
  logic         out;
`ifdef PISO_VALID_EN
  logic         valid;
`endif

  int vectors;
  int miscompares;

  logic [1:0]   exp_q[$];
  logic [W-1:0] m_sr;
  int           m_cnt;

  piso #(.WIDTH(W)) dut (
    .in   (d_in),
    .rst  (rst),
    .clk  (clk),
    .ld   (ld),
    .out  (out)
`ifdef PISO_VALID_EN
    ,
    .valid(valid)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] observed();
`ifdef PISO_VALID_EN
    return {valid, out};
`else
    return {1'b0, out};
`endif
  endfunction

  function automatic void model_edge(input logic l, input logic [W-1:0] d);
    if (l) begin
      m_sr  = d;
      m_cnt = W;
    end else begin
      m_sr = m_sr << 1;
      if (m_cnt > 0) m_cnt--;
    end
  endfunction

  function automatic void model_reset();
    m_sr  = '0;
    m_cnt = 0;
  endfunction

  // driver: called at a negedge; applies one edge, then checks at the next negedge
  task automatic cycle(input logic l, input logic [W-1:0] d, output logic [1:0] obs);
    logic [1:0] e;
    ld   = l;
    d_in = d;
    model_edge(l, d);
    exp_q.push_back({(m_cnt != 0), m_sr[W-1]});
    @(posedge clk);
    @(negedge clk);
    e   = exp_q.pop_front();
    obs = observed();
    vectors++;
`ifdef PISO_VALID_EN
    if (obs !== e) begin
      miscompares++;
      $display("FAIL cycle t=%0t ld=%b in=%h: {valid,out} got %b want %b", $time, l, d, obs, e);
    end
`else
    if (obs[0] !== e[0]) begin
      miscompares++;
      $display("FAIL cycle t=%0t ld=%b in=%h: out got %b want %b", $time, l, d, obs[0], e[0]);
    end
`endif
  endtask

  // Runs a load followed by n shifts and collects the out and valid bits, first bit in the MSB.
  task automatic run_word(input logic [W-1:0] w, input int n,
                          output logic [7:0] outs, output logic [7:0] vals);
    logic [1:0] o;
    outs = '0;
    vals = '0;
    cycle(1'b1, w, o);
    outs = {outs[6:0], o[0]};
    vals = {vals[6:0], o[1]};
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, $urandom_range(0, 15), o);
      outs = {outs[6:0], o[0]};
      vals = {vals[6:0], o[1]};
    end
  endtask

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [1:0] o;
    rst  = 1'b0;
    ld   = 1'b0;
    d_in = '0;
    model_reset();
    #2;
    vectors++;
    if (observed() !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_initial: got %b want 00", observed());
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'h0, o);
    cycle(1'b1, 4'hA, o);
    // asynchronous assertion between edges with sr nonzero
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (observed() !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_async: got %b want 00", observed());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, o);
  endtask

  task automatic test_shift_order();
    logic [7:0] outs, vals;
    run_word(4'hC, 4, outs, vals);
    check_lit("shift_c_out", outs, 8'b0001_1000);
`ifdef PISO_VALID_EN
    check_lit("shift_c_valid", vals, 8'b0001_1110);
`endif
    run_word(4'h1, 4, outs, vals);
    check_lit("shift_1_out", outs, 8'b0000_0010);
    run_word(4'h7, 4, outs, vals);
    check_lit("shift_7_out", outs, 8'b0000_1110);
  endtask

  task automatic test_load_wins();
    logic [7:0] outs, vals;
    run_word(4'hC, 3, outs, vals);
    run_word(4'hF, 6, outs, vals);
    check_lit("load_wins_out", outs, 8'b0111_1000);
`ifdef PISO_VALID_EN
    check_lit("load_wins_valid", vals, 8'b0111_1000);
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] outs, vals;
    logic [1:0] o;
    cycle(1'b1, 4'h0, o);
    vectors++;
    if (o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: got %b want 0", o[0]);
    end
    run_word(4'h5, 4, outs, vals);
    check_lit("b2b_out", outs, 8'b0000_1010);
  endtask

  task automatic test_ld_held();
    logic [7:0] outs;
    logic [1:0] o;
    outs = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h9, o);
      outs = {outs[6:0], o[0]};
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'h0, o);
      outs = {outs[6:0], o[0]};
    end
    check_lit("ld_held_out", outs, 8'b0111_0010);
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] outs, vals;
    logic [1:0] o;
    run_word(4'hF, 2, outs, vals);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (observed() !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_word: got %b want 00", observed());
    end
    // inputs at X while reset is held must not matter
    ld   = 1'bx;
    d_in = 'x;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (observed() !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_x_inputs: got %b want 00", observed());
    end
    rst = 1'b1;
    outs = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'h0, o);
      outs = {outs[6:0], o[0]};
    end
    check_lit("after_reset_zeros", outs, 8'h00);
  endtask

  task automatic test_random();
    logic [1:0] o;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 4) == 0), W'($urandom_range(0, 15)), o);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_shift_order();
    test_load_wins();
    test_back_to_back();
    test_ld_held();
    test_reset_mid_word();
    test_random();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
